ahb_master_arbiter: RTL and testbench
=====================================

# ahb_master_arbiter

Round-robin address-phase arbiter that shares one AHB-Lite slave-side bus between up to 26 masters. It generates the one-hot select vectors that drive the OR-based parallel muxes (mux2…mux26): one for the address/control path and one for the write-data path. It also returns a per-master HREADY that stalls masters that are not granted. It sits in the interconnect between the master ports and the shared slave decoder.

## Interface
- NM, 4: number of masters, legal range 2..26.
- hclk  input  1  bus clock; all state updates on the rising edge.
- hrst  input  1  asynchronous, active-high reset.
- htrans_m  input  2*NM  HTRANS of each master, packed; master i occupies [2i+1:2i].
- hmastlock_m  input  NM  HMASTLOCK of each master.
- hready  input  1  HREADY returned from the shared slave side.
- addr_sel  output  NM  one-hot address-phase grant; this drives the sel inputs of the address/control muxes.
- data_sel  output  NM  one-hot data-phase owner; this drives the sel inputs of the write-data mux.
- hready_m  output  NM  HREADY presented to each master.

## Operation
- A master is requesting when htrans_m[i][1] is 1 (NONSEQ or SEQ).
- Owner: the master flagged in addr_sel. At most one bit of addr_sel or data_sel is ever set.
- States:
  - PARK: no master is requesting. addr_sel holds the last owner; after reset this is master 0.
  - OWN: the owner is running transfers.
  - LOCK: the owner asserts hmastlock_m.
- Arbitration is evaluated only in cycles with hready=1. The new grant is registered into addr_sel on that edge.
- Switching is forbidden when any of these holds; in each case addr_sel stays unchanged:
  - the owner's htrans is SEQ or BUSY (burst continues);
  - the state is LOCK;
  - the owner's hmastlock is 1.
- Otherwise the winner is the next requesting master in round-robin order, starting at owner+1 and wrapping from NM-1 to 0.
  - If no other master is requesting and the owner is, the owner keeps the grant.
  - If nobody is requesting, go to PARK and keep addr_sel.
- State transitions:
  - PARK→OWN: any request.
  - OWN→LOCK: the owner's hmastlock=1 in a cycle with hready=1.
  - LOCK→OWN: the owner's hmastlock=0 with htrans IDLE or NONSEQ, in a cycle with hready=1.
  - OWN→PARK: no requests in a cycle with hready=1.
- data_sel <= addr_sel when hready=1 and the owner's htrans is NONSEQ or SEQ. When hready=1 and the owner's htrans is IDLE or BUSY, data_sel <= 0.
- hready_m[i]:
  - equals hready when i is the data-phase owner or the address owner;
  - is 0 when i is requesting but not granted;
  - is 1 otherwise (idle, non-owner master).
- Simultaneous new requests are resolved by round-robin order only; lower index has no other precedence.

## Timing
- Reset values: addr_sel = 1 (master 0), data_sel = 0, state = PARK, round-robin pointer = 0, hready_m = all ones.
- Latency from a new request by a non-owner to grant: 1 cycle with hready=1. The request is stalled via hready_m=0 during that cycle.
- Grant is held for the whole cycle in which the slave inserts wait states (hready=0). No decision is taken while hready=0.
- data_sel lags addr_sel by exactly one hready=1 edge.
- If reset asserts mid-transfer, all outputs go to their reset values immediately (asynchronously). The interrupted transfer is not resumed.

## Configuration
- AHB_ARB_LOCK_EN:
  - Defined: hmastlock_m is honoured and the LOCK state exists.
  - Undefined: hmastlock_m is ignored and LOCK is unreachable. Arbitration respects only burst continuation (SEQ/BUSY).

## Structure
- Shared package ahb_pkg:
  - HTRANS constants IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11;
  - the arbiter state enum;
  - the maximum master count (26).
- Sub-module rr_pick: a combinational round-robin one-hot picker with inputs req[NM] and ptr[NM] (one-hot last winner) and output gnt[NM]. It is reused by the slave-side response arbiter.

## Test plan
- Reset with NM=4: addr_sel=4'b0001, data_sel=0, hready_m=4'b1111. Releasing reset with all htrans IDLE leaves the state in PARK.
- Masters 1 and 2 both issue NONSEQ at once with hready=1:
  - master 1 is granted first (addr_sel=4'b0010) and hready_m[2]=0;
  - master 2 is granted one transfer later;
  - data_sel follows addr_sel one cycle behind.
- Master 3 runs a 4-beat INCR4 (NONSEQ, SEQ, SEQ, SEQ) while master 0 requests: addr_sel stays 4'b1000 for all 4 beats, then switches to 4'b0001.
- The slave holds hready=0 for 3 cycles mid-burst: addr_sel, data_sel and the state are unchanged, and all hready_m of active masters are 0.
- With AHB_ARB_LOCK_EN, master 1 asserts hmastlock over two NONSEQ transfers while master 2 requests: master 2 is not granted until master 1 deasserts hmastlock. Without the macro, master 2 is granted after master 1's first transfer.
- hrst is asserted during a granted burst of master 2: addr_sel=4'b0001 and data_sel=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite definitions for the interconnect: HTRANS
//               encodings, arbiter state type and the master-count ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  // Upper bound on the number of masters one arbiter can serve
  localparam int MAX_MASTERS = 26;

  // Address-phase arbiter state
  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_OWN  = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin one-hot picker. Searches req
//               starting just above the one-hot last winner ptr and wraps.
//               gnt is zero when nothing is requesting.
// Ports       : req [NM] - request vector
//               ptr [NM] - one-hot last winner
//               gnt [NM] - one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NM = 4
) (
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] ptr,
  output logic [NM-1:0] gnt
);

  localparam logic [NM-1:0] c_one = NM'(1);

  logic [NM-1:0] w_mask;
  logic [NM-1:0] w_hi;
  logic [NM-1:0] w_sel;

  // Bits strictly above the last winner; an all-zero ptr selects none,
  // which degenerates to a plain lowest-index pick.
  assign w_mask = ~(ptr | (ptr - c_one));
  assign w_hi   = req & w_mask;
  // Prefer requesters above ptr, otherwise wrap to the full vector
  assign w_sel  = (|w_hi) ? w_hi : req;
  // Isolate the lowest set bit
  assign gnt    = w_sel & (~w_sel + c_one);

endmodule

`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
// ============================================================================
// Module      : ahb_master_arbiter
// Description : Round-robin AHB-Lite address-phase arbiter for NM masters
//               (legal range 2..MAX_MASTERS). Produces one-hot select vectors
//               for the address/control mux and the write-data mux, and a
//               per-master HREADY that stalls ungranted requesters.
// Ports       : hclk        - bus clock
//               hrst        - asynchronous active-high reset
//               htrans_m    - packed HTRANS, master i at [2i+1:2i]
//               hmastlock_m - HMASTLOCK per master
//               hready      - HREADY from the shared slave side
//               addr_sel    - one-hot address-phase grant
//               data_sel    - one-hot data-phase owner
//               hready_m    - HREADY presented to each master
// Config      : AHB_ARB_LOCK_EN - when defined, hmastlock_m is honoured and
//               the LOCK state is reachable; otherwise only SEQ/BUSY bursts
//               hold the grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int NM = 4
) (
  input  logic            hclk,
  input  logic            hrst,
  input  logic [2*NM-1:0] htrans_m,
  input  logic [NM-1:0]   hmastlock_m,
  input  logic            hready,
  output logic [NM-1:0]   addr_sel,
  output logic [NM-1:0]   data_sel,
  output logic [NM-1:0]   hready_m
);

  arb_state_e    r_state;
  logic [NM-1:0] r_addr_sel;
  logic [NM-1:0] r_data_sel;

  logic [NM-1:0] w_req;
  logic [NM-1:0] w_gnt;
  logic [NM-1:0] w_hready_m;
  logic [1:0]    w_own_trans;
  logic          w_own_lock;
  logic          w_hold;

  // Request vector and owner's HTRANS (OR-mux over the one-hot owner)
  always_comb begin
    w_req       = '0;
    w_own_trans = IDLE;
    for (int i = 0; i < NM; i++) begin
      w_req[i] = htrans_m[2*i+1];
      if (r_addr_sel[i]) begin
        w_own_trans = w_own_trans | htrans_m[2*i +: 2];
      end
    end
  end

`ifdef AHB_ARB_LOCK_EN
  assign w_own_lock = |(hmastlock_m & r_addr_sel);
`else
  logic w_unused_lock;
  assign w_own_lock    = 1'b0;
  assign w_unused_lock = ^hmastlock_m;
`endif

  // The grant may not move while a burst continues or a locked sequence runs
  assign w_hold = (w_own_trans == SEQ) || (w_own_trans == BUSY) ||
                  (r_state == ST_LOCK) || w_own_lock;

  // The current owner doubles as the round-robin pointer
  rr_pick #(
    .NM (NM)
  ) u_rr_pick (
    .req (w_req),
    .ptr (r_addr_sel),
    .gnt (w_gnt)
  );

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_state    <= ST_PARK;
      r_addr_sel <= NM'(1);
      r_data_sel <= '0;
    end else if (hready) begin
      // An empty w_gnt means nobody requests: keep the parked owner
      if (!w_hold && (|w_gnt)) begin
        r_addr_sel <= w_gnt;
      end
      // Only NONSEQ/SEQ carry a data phase
      r_data_sel <= w_own_trans[1] ? r_addr_sel : '0;

      case (r_state)
        ST_PARK: begin
          if (|w_req) r_state <= ST_OWN;
        end
        ST_OWN: begin
          if (w_own_lock)   r_state <= ST_LOCK;
          else if (!(|w_req)) r_state <= ST_PARK;
        end
        ST_LOCK: begin
          if (!w_own_lock && !w_own_trans[0]) r_state <= ST_OWN;
        end
        default: r_state <= ST_PARK;
      endcase
    end
  end

  // Owners see the slave's HREADY; ungranted requesters are stalled
  always_comb begin
    w_hready_m = '1;
    for (int i = 0; i < NM; i++) begin
      if (r_addr_sel[i] || r_data_sel[i]) w_hready_m[i] = hready;
      else                                w_hready_m[i] = ~w_req[i];
    end
  end

  assign addr_sel = r_addr_sel;
  assign data_sel = r_data_sel;
  assign hready_m = w_hready_m;

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
// ============================================================================
// Module      : tb_ahb_master_arbiter
// Description : Directed, table-driven bench for ahb_master_arbiter (NM=4).
//               Each row is driven at the falling edge and its expectations
//               describe the state left by the previous rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam int NM = 4;

  logic            hclk;
  logic            hrst;
  logic [2*NM-1:0] htrans_m;
  logic [NM-1:0]   hmastlock_m;
  logic            hready;
  logic [NM-1:0]   addr_sel;
  logic [NM-1:0]   data_sel;
  logic [NM-1:0]   hready_m;

  int n_checks;
  int n_errors;

  ahb_master_arbiter #(
    .NM (NM)
  ) dut (
    .hclk        (hclk),
    .hrst        (hrst),
    .htrans_m    (htrans_m),
    .hmastlock_m (hmastlock_m),
    .hready      (hready),
    .addr_sel    (addr_sel),
    .data_sel    (data_sel),
    .hready_m    (hready_m)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [7:0] trans;
    logic       rdy;
    logic [3:0] exp_addr;
    logic [3:0] exp_data;
    logic [3:0] exp_hrm;
    arb_state_e exp_st;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] t, input logic [3:0] l, input logic r);
    @(negedge hclk);
    htrans_m    = t;
    hmastlock_m = l;
    hready      = r;
    #1;
  endtask

  task automatic chk_all(input string name, input logic [3:0] ea, input logic [3:0] ed,
                         input logic [3:0] eh, input arb_state_e es);
    chk({name, "_addr"}, addr_sel, ea);
    chk({name, "_data"}, data_sel, ed);
    chk({name, "_hrm"}, hready_m, eh);
    chk({name, "_state"}, 4'(dut.r_state), 4'(es));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // htrans_m layout: {m3, m2, m1, m0}
    vec[0]  = '{8'b00_00_00_00, 1'b1, 4'b0001, 4'b0000, 4'b1111, ST_PARK};
    vec[1]  = '{8'b00_10_10_00, 1'b1, 4'b0001, 4'b0000, 4'b1001, ST_PARK};
    vec[2]  = '{8'b00_10_10_00, 1'b1, 4'b0010, 4'b0000, 4'b1011, ST_OWN};
    vec[3]  = '{8'b00_10_00_00, 1'b1, 4'b0100, 4'b0010, 4'b1111, ST_OWN};
    vec[4]  = '{8'b00_00_00_00, 1'b1, 4'b0100, 4'b0100, 4'b1111, ST_OWN};
    vec[5]  = '{8'b00_00_00_00, 1'b1, 4'b0100, 4'b0000, 4'b1111, ST_PARK};
    vec[6]  = '{8'b10_00_00_00, 1'b1, 4'b0100, 4'b0000, 4'b0111, ST_PARK};
    vec[7]  = '{8'b10_00_00_00, 1'b1, 4'b1000, 4'b0000, 4'b1111, ST_OWN};
    vec[8]  = '{8'b11_00_00_10, 1'b1, 4'b1000, 4'b1000, 4'b1110, ST_OWN};
    vec[9]  = '{8'b11_00_00_10, 1'b0, 4'b1000, 4'b1000, 4'b0110, ST_OWN};
    vec[10] = '{8'b11_00_00_10, 1'b0, 4'b1000, 4'b1000, 4'b0110, ST_OWN};
    vec[11] = '{8'b11_00_00_10, 1'b0, 4'b1000, 4'b1000, 4'b0110, ST_OWN};
    vec[12] = '{8'b11_00_00_10, 1'b1, 4'b1000, 4'b1000, 4'b1110, ST_OWN};
    vec[13] = '{8'b11_00_00_10, 1'b1, 4'b1000, 4'b1000, 4'b1110, ST_OWN};
    vec[14] = '{8'b00_00_00_10, 1'b1, 4'b1000, 4'b1000, 4'b1110, ST_OWN};
    vec[15] = '{8'b00_00_00_10, 1'b1, 4'b0001, 4'b0000, 4'b1111, ST_OWN};
    vec[16] = '{8'b00_00_00_00, 1'b1, 4'b0001, 4'b0001, 4'b1111, ST_OWN};
    vec[17] = '{8'b00_00_00_00, 1'b1, 4'b0001, 4'b0000, 4'b1111, ST_PARK};

    // Reset state
    hrst        = 1'b1;
    htrans_m    = '0;
    hmastlock_m = '0;
    hready      = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    #1;
    chk_all("reset", 4'b0001, 4'b0000, 4'b1111, ST_PARK);
    @(negedge hclk);
    hrst = 1'b0;

    // Table: arbitration, round robin, INCR4 burst with wait states
    for (int i = 0; i < 18; i++) begin
      drive(vec[i].trans, 4'b0000, vec[i].rdy);
      chk_all($sformatf("vec%0d", i), vec[i].exp_addr, vec[i].exp_data,
              vec[i].exp_hrm, vec[i].exp_st);
    end

    // Locked transfers of master 1 while master 2 requests
    drive(8'b00_00_10_00, 4'b0000, 1'b1);
    chk_all("lk0", 4'b0001, 4'b0000, 4'b1101, ST_PARK);
    drive(8'b00_10_10_00, 4'b0010, 1'b1);
    chk_all("lk1", 4'b0010, 4'b0000, 4'b1011, ST_OWN);
`ifdef AHB_ARB_LOCK_EN
    drive(8'b00_10_10_00, 4'b0010, 1'b1);
    chk_all("lk2", 4'b0010, 4'b0010, 4'b1011, ST_LOCK);
    drive(8'b00_10_00_00, 4'b0000, 1'b1);
    chk_all("lk3", 4'b0010, 4'b0010, 4'b1011, ST_LOCK);
    drive(8'b00_10_00_00, 4'b0000, 1'b1);
    chk_all("lk4", 4'b0010, 4'b0000, 4'b1011, ST_OWN);
    drive(8'b00_10_00_00, 4'b0000, 1'b1);
    chk_all("lk5", 4'b0100, 4'b0000, 4'b1111, ST_OWN);
`else
    drive(8'b00_10_10_00, 4'b0010, 1'b1);
    chk_all("nolk2", 4'b0100, 4'b0010, 4'b1111, ST_OWN);
`endif

    // Drain, then start a master-2 burst and reset in the middle of it
    drive(8'b00_00_00_00, 4'b0000, 1'b1);
    drive(8'b00_00_00_00, 4'b0000, 1'b1);
    drive(8'b00_00_00_00, 4'b0000, 1'b1);
    drive(8'b00_10_00_00, 4'b0000, 1'b1);
    drive(8'b00_10_00_00, 4'b0000, 1'b1);
    drive(8'b00_11_00_00, 4'b0000, 1'b1);
    chk("pre_rst_addr", addr_sel, 4'b0100);
    chk("pre_rst_data", data_sel, 4'b0100);
    #1;
    hrst = 1'b1;
    #1;
    // Still before the next rising edge: the reset must act asynchronously
    chk("async_rst_addr", addr_sel, 4'b0001);
    chk("async_rst_data", data_sel, 4'b0000);
    chk("async_rst_state", 4'(dut.r_state), 4'(ST_PARK));
    @(negedge hclk);
    htrans_m = '0;
    hrst     = 1'b0;
    drive(8'b00_00_00_00, 4'b0000, 1'b1);
    chk_all("post_rst", 4'b0001, 4'b0000, 4'b1111, ST_PARK);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
